// File: rtl/sd_pkg.sv
// Shared constants and types for the SD command transmitter slice.
package sd_pkg;

    localparam int         CMD_FRAME_BITS  = 48;
    localparam logic [6:0] CRC7_POLY       = 7'h09;
    localparam int         NCC_GAP_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        GAP
    } sd_state_t;

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Command request interface: valid/ready handshake, command fields and completion status.
// The cmd_crc field exists only when SD_CMD_TX_CRC_EN is undefined.
interface sd_cmd_tx_if;

    logic        start_valid;
    logic        start_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
`ifndef SD_CMD_TX_CRC_EN
    logic [6:0]  cmd_crc;
`endif
    logic        busy;
    logic        done;

`ifdef SD_CMD_TX_CRC_EN
    modport master (output start_valid, cmd_index, cmd_arg,
                    input  start_ready, busy, done);
    modport slave  (input  start_valid, cmd_index, cmd_arg,
                    output start_ready, busy, done);
`else
    modport master (output start_valid, cmd_index, cmd_arg, cmd_crc,
                    input  start_ready, busy, done);
    modport slave  (input  start_valid, cmd_index, cmd_arg, cmd_crc,
                    output start_ready, busy, done);
`endif

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 generator (x^7 + x^3 + 1), one message bit per enabled clock, MSB first.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;

    assign fb = bit_in ^ crc[6];

    always_ff @(posedge clk) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: builds the 48-bit command frame and shifts it out on sd_clk falls.
// Build option SD_CMD_TX_CRC_EN: hardware CRC7; otherwise cmd_crc is sent unchanged.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int NCC_GAP = NCC_GAP_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sd_clk,
    sd_cmd_tx_if.slave req,
    output logic       cmd_out,
    output logic       cmd_oe
);

    localparam logic [5:0] TOP_BIT  = 6'(CMD_FRAME_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(NCC_GAP - 1);

    sd_state_t state;
    sd_state_t state_nxt;

    logic                      sd_clk_d;
    logic                      fall;
    logic                      accept;
    logic                      drive;
    logic                      frame_end;
    logic                      gap_last;
    logic [5:0]                bit_cnt;
    logic [5:0]                next_idx;
    logic [7:0]                gap_cnt;
    logic [5:0]                idx_q;
    logic [31:0]               arg_q;
    logic [6:0]                crc_bits;
    logic [CMD_FRAME_BITS-1:0] frame;
    logic                      cmd_out_nxt;
    logic                      cmd_oe_nxt;
    logic                      done_nxt;
    logic                      done_q;

    assign fall      = sd_clk_d & ~sd_clk;
    assign accept    = req.start_valid & req.start_ready;
    assign frame_end = (state == SHIFT) && (bit_cnt == 6'd0);
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign frame     = {2'b01, idx_q, arg_q, crc_bits, 1'b1};

    // bit_cnt holds the index of the bit currently on the line; WAIT launches the top bit
    assign next_idx = ((state == SHIFT) && (bit_cnt != 6'd0)) ? (bit_cnt - 6'd1) : TOP_BIT;
    assign drive    = fall && ((state == WAIT) || ((state == SHIFT) && (bit_cnt != 6'd0)));

    assign req.start_ready = (state == IDLE);
    assign req.busy        = (state != IDLE);
    assign req.done        = done_q;

`ifdef SD_CMD_TX_CRC_EN
    logic crc_en;

    assign crc_en = drive && (next_idx >= 6'd8);

    sd_crc7 u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .en     (crc_en),
        .bit_in (frame[next_idx]),
        .crc    (crc_bits)
    );
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc_bits <= '0;
        end else if (accept) begin
            crc_bits <= req.cmd_crc;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)               state_nxt = WAIT;
            WAIT:    if (fall)                 state_nxt = SHIFT;
            SHIFT:   if (fall && frame_end)    state_nxt = GAP;
            GAP:     if (fall && gap_last)     state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Line outputs only move on a fall; the frame-ending fall releases CMD high
    always_comb begin
        cmd_out_nxt = cmd_out;
        cmd_oe_nxt  = cmd_oe;
        done_nxt    = 1'b0;
        if (drive) begin
            cmd_out_nxt = frame[next_idx];
            cmd_oe_nxt  = 1'b1;
        end
        if (fall && frame_end) begin
            cmd_out_nxt = 1'b1;
            cmd_oe_nxt  = 1'b0;
        end
        if (fall && (state == GAP) && gap_last) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sd_clk_d <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            idx_q    <= '0;
            arg_q    <= '0;
            cmd_out  <= 1'b1;
            cmd_oe   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sd_clk_d <= sd_clk;
            cmd_out  <= cmd_out_nxt;
            cmd_oe   <= cmd_oe_nxt;
            done_q   <= done_nxt;
            if (accept) begin
                idx_q   <= req.cmd_index;
                arg_q   <= req.cmd_arg;
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else if (fall) begin
                case (state)
                    WAIT:  bit_cnt <= TOP_BIT;
                    SHIFT: if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
                    GAP:   gap_cnt <= gap_last ? 8'd0 : (gap_cnt + 8'd1);
                    default: ;
                endcase
            end
        end
    end

endmodule
